emg_stim_blanking_scheduler: RTL and testbench
==============================================

// Module: emg_stim_blanking_scheduler
// PURPOSE
//  Arbitrates the EMG ADC between acquisition and stimulation in the combined EMG/NMES system.
//  - EMG conversion requests are granted only outside the stimulation and artifact windows.
//  - The stimulation artifact window is the CAT/ANO/DIS phases plus a programmable post-pulse blanking window.
//  - Sits between the EMG acquisition sequencer (request side) and the ADC START input.
//  - Monitors the stimulus-generator phase outputs. Reports dropped requests for data-quality bookkeeping.
// PARAMETERS
//  BLANK_CYCLES  200  post-stimulus blanking length in CLK cycles (>=1)
//  CH_W          4    EMG channel index width (16 channels)
//  CNT_W         8    width of the dropped-request counter
// PORTS
//  CLK           in   1      system clock; all logic on rising edge
//  RESET         in   1      synchronous, active-high reset
//  ENABLE        in   1      block enable; low forces IDLE
//  CAT_ST        in   1      cathodic phase active (from stimulus generator)
//  ANO_ST        in   1      anodic phase active
//  DIS_ST        in   1      discharge phase active
//  CONV_REQ      in   1      1-cycle pulse: sequencer requests one conversion
//  CH_IDX        in   CH_W   channel index accompanying CONV_REQ
//  START_EMG     out  1      1-cycle pulse: start ADC conversion
//  GRANT_CH      out  CH_W   channel index of the last granted request
//  BLANK_ACTIVE  out  1      high in STIM or HOLDOFF
//  DROP_CNT      out  CNT_W  saturating count of dropped requests
//  REPLAY_FLAG   out  1      high with START_EMG when it is a replayed request (SAMPLE_REPLAY_EN only; else tied 0)
// BEHAVIOUR
//  Reset: all outputs 0; state=IDLE; blank counter=0; pending slot empty.
//  stim_q: registered (CAT_ST|ANO_ST|DIS_ST), 1 cycle latency. FSM and gating use stim_q only.
//  FSM states:
//   IDLE: entered when ENABLE=0 (from any state, next cycle).
//    - Pending slot cleared; DROP_CNT held; requests ignored (not counted).
//    - ENABLE=1 -> ACQ if stim_q=0, else STIM.
//   ACQ: CONV_REQ & !stim_q -> next cycle START_EMG=1, GRANT_CH=CH_IDX. Fixed latency: 1 cycle.
//    - stim_q=1 -> STIM. A CONV_REQ in that same cycle is dropped.
//   STIM: every CONV_REQ is dropped.
//    - stim_q=0 -> HOLDOFF; counter loads BLANK_CYCLES-1.
//   HOLDOFF: requests dropped; counter decrements each cycle.
//    - Counter==0 -> ACQ.
//    - stim_q=1 (re-stimulation) -> STIM immediately; on the next exit the counter reloads in full.
//  BLANK_ACTIVE = (state==STIM || state==HOLDOFF), registered with the state.
//  Drop: DROP_CNT increments by 1 per dropped request and saturates at 2^CNT_W-1. It clears only on RESET.
//  START_EMG is never high on two consecutive cycles unless CONV_REQ was high on two consecutive cycles in ACQ.
//  RESET mid-pulse or mid-holdoff: next cycle IDLE. No START_EMG is issued in the cycle after RESET.
// CONFIGURATION
//  SAMPLE_REPLAY_EN defined:
//   - One-entry pending slot. The first request dropped in STIM/HOLDOFF is stored (channel index), and DROP_CNT still increments.
//   - Later drops do not overwrite the slot.
//   - On the first ACQ cycle, the slot is issued: START_EMG=1, GRANT_CH=stored, REPLAY_FLAG=1. The slot is then cleared.
//   - A fresh CONV_REQ in that same first ACQ cycle is granted on the following cycle; the request is held one cycle, no drop.
//   - ENABLE=0 or RESET empties the slot.
//  Undefined: no slot; REPLAY_FLAG tied 0; behaviour exactly as above.
// TESTING
//  T1 reset: RESET=1 for 2 cycles -> all outputs 0; no START_EMG while CONV_REQ toggles during reset.
//  T2 grant latency: ENABLE=1, no stim, CONV_REQ with CH_IDX=5 -> START_EMG=1 and GRANT_CH=5 exactly 1 cycle later.
//  T3 blanking:
//   - CAT_ST high 150 cycles, then DIS_ST 10 cycles. BLANK_ACTIVE rises 2 cycles after CAT_ST and stays high until 200 cycles after stim_q falls.
//   - 3 requests inside that window -> DROP_CNT=3 and no START_EMG.
//  T4 re-stim: CAT_ST re-asserted 50 cycles into HOLDOFF -> STIM. The next HOLDOFF lasts a full 200 cycles.
//  T5 saturation: 300 requests while blanked with CNT_W=8 -> DROP_CNT=255.
//  T6 replay (SAMPLE_REPLAY_EN):
//   - Drop CH_IDX=3, then CH_IDX=7, while blanked.
//   - On return to ACQ: one START_EMG with GRANT_CH=3 and REPLAY_FLAG=1. DROP_CNT=2.
//   - With ENABLE dropped mid-blank: no replay.

Source files
------------

// File: rtl/emg_stim_blanking_scheduler.sv
// emg_stim_blanking_scheduler: gates EMG ADC starts around stimulation pulses and post-pulse blanking (optional replay slot: SAMPLE_REPLAY_EN)
module emg_stim_blanking_scheduler #(
  parameter int BLANK_CYCLES = 200,
  parameter int CH_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             CAT_ST,
  input  logic             ANO_ST,
  input  logic             DIS_ST,
  input  logic             CONV_REQ,
  input  logic [CH_W-1:0]  CH_IDX,
  output logic             START_EMG,
  output logic [CH_W-1:0]  GRANT_CH,
  output logic             BLANK_ACTIVE,
  output logic [CNT_W-1:0] DROP_CNT,
  output logic             REPLAY_FLAG
);
  localparam int BW = $clog2(BLANK_CYCLES + 1);
  localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, ACQ, STIM, HOLD} state_t;
  state_t state;
  logic stim_q;
  logic [BW-1:0] cnt;
  logic blanked;
  logic drop_fresh;
  logic [1:0] drop_inc;
  logic [CNT_W:0] drop_sum;
`ifdef SAMPLE_REPLAY_EN
  logic slot_v, hold_v;
  logic [CH_W-1:0] slot_ch, hold_ch;
  logic drop_held;
  // a held request that meets a new stimulus is discarded and counted as a drop
  always_comb begin
    blanked = state == STIM || state == HOLD;
    drop_fresh = ENABLE & CONV_REQ & (blanked | (state == ACQ & (stim_q | hold_v)));
    drop_held = ENABLE & (state == ACQ) & hold_v & stim_q;
    drop_inc = {1'b0, drop_fresh} + {1'b0, drop_held};
    drop_sum = {1'b0, DROP_CNT} + (CNT_W+1)'(drop_inc);
  end
`else
  assign REPLAY_FLAG = 1'b0;
  // a request is lost whenever it arrives while stimulation is seen or blanking runs
  always_comb begin
    blanked = state == STIM || state == HOLD;
    drop_fresh = ENABLE & CONV_REQ & (blanked | (state == ACQ & stim_q));
    drop_inc = {1'b0, drop_fresh};
    drop_sum = {1'b0, DROP_CNT} + (CNT_W+1)'(drop_inc);
  end
`endif
  // phase sampling, arbitration FSM, blanking counter and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      stim_q <= 1'b0;
      cnt <= '0;
      START_EMG <= 1'b0;
      GRANT_CH <= '0;
      BLANK_ACTIVE <= 1'b0;
      DROP_CNT <= '0;
`ifdef SAMPLE_REPLAY_EN
      REPLAY_FLAG <= 1'b0;
      slot_v <= 1'b0;
      slot_ch <= '0;
      hold_v <= 1'b0;
      hold_ch <= '0;
`endif
    end else begin
      stim_q <= CAT_ST | ANO_ST | DIS_ST;
      START_EMG <= 1'b0;
      DROP_CNT <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
`ifdef SAMPLE_REPLAY_EN
      REPLAY_FLAG <= 1'b0;
      if (drop_fresh && blanked && !slot_v) begin
        slot_v <= 1'b1;
        slot_ch <= CH_IDX;
      end
`endif
      if (!ENABLE) begin
        state <= IDLE;
        BLANK_ACTIVE <= 1'b0;
`ifdef SAMPLE_REPLAY_EN
        slot_v <= 1'b0;
        hold_v <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            state <= stim_q ? STIM : ACQ;
            BLANK_ACTIVE <= stim_q;
          end
          ACQ: begin
            if (stim_q) begin
              state <= STIM;
              BLANK_ACTIVE <= 1'b1;
`ifdef SAMPLE_REPLAY_EN
              hold_v <= 1'b0;
            end else if (hold_v) begin
              START_EMG <= 1'b1;
              GRANT_CH <= hold_ch;
              hold_v <= 1'b0;
            end else if (slot_v) begin
              START_EMG <= 1'b1;
              GRANT_CH <= slot_ch;
              REPLAY_FLAG <= 1'b1;
              slot_v <= 1'b0;
              hold_v <= CONV_REQ;
              hold_ch <= CH_IDX;
`endif
            end else if (CONV_REQ) begin
              START_EMG <= 1'b1;
              GRANT_CH <= CH_IDX;
            end
          end
          STIM: begin
            if (!stim_q) begin
              state <= HOLD;
              cnt <= BLANK_LOAD;
            end
          end
          HOLD: begin
            if (stim_q) state <= STIM;
            else if (cnt == '0) begin
              state <= ACQ;
              BLANK_ACTIVE <= 1'b0;
            end else cnt <= cnt - BW'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_emg_stim_blanking_scheduler.sv
// tb_emg_stim_blanking_scheduler: directed scenarios plus randomized traffic against a window-based reference model
module tb_emg_stim_blanking_scheduler;
  localparam int B = 200;
  localparam int MAXD = 255;
  localparam int INF = 1 << 20;
  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, cat = 1'b0, ano = 1'b0, dis = 1'b0, req = 1'b0;
  logic [3:0] ch = '0;
  logic start, blank, flag;
  logic [3:0] grant;
  logic [7:0] drop;
  int total = 0, bad = 0;
  // reference model: blanking = "a stimulus was seen within the last B+1 enabled cycles"
  int m_since = INF, m_drops = 0;
  bit m_active = 0, m_stim_q = 0, m_start = 0, m_flag = 0;
  bit slot_v = 0, hold_v = 0;
  logic [3:0] m_grant = '0, slot_ch = '0, hold_ch = '0;

  emg_stim_blanking_scheduler dut (
    .CLK(clk), .RESET(rst), .ENABLE(en), .CAT_ST(cat), .ANO_ST(ano), .DIS_ST(dis),
    .CONV_REQ(req), .CH_IDX(ch), .START_EMG(start), .GRANT_CH(grant),
    .BLANK_ACTIVE(blank), .DROP_CNT(drop), .REPLAY_FLAG(flag)
  );

  always #5 clk = ~clk;

  function automatic int exp_drop();
    return m_drops > MAXD ? MAXD : m_drops;
  endfunction

  function automatic bit exp_blank();
    return m_since <= B;
  endfunction

  task automatic tick();
    bit bl, aq;
    @(posedge clk);
    bl = m_since <= B;
    aq = m_active && !bl;
    if (rst) begin
      m_since = INF; m_drops = 0; m_active = 0; m_stim_q = 0;
      m_start = 0; m_flag = 0; m_grant = '0; slot_v = 0; hold_v = 0;
    end else begin
      m_start = 0;
      m_flag = 0;
      if (!en) begin
        slot_v = 0;
        hold_v = 0;
      end else if (aq) begin
        if (m_stim_q) begin
          m_drops += int'(req) + int'(hold_v);
          hold_v = 0;
        end else if (hold_v) begin
          m_start = 1; m_grant = hold_ch; hold_v = 0;
          m_drops += int'(req);
        end else if (slot_v) begin
          m_start = 1; m_flag = 1; m_grant = slot_ch; slot_v = 0;
          hold_v = req; hold_ch = ch;
        end else if (req) begin
          m_start = 1; m_grant = ch;
        end
      end else if (bl && req) begin
        m_drops++;
`ifdef SAMPLE_REPLAY_EN
        if (!slot_v) begin slot_v = 1; slot_ch = ch; end
`endif
      end
      m_since = !en ? INF : m_stim_q ? 0 : (m_since < INF ? m_since + 1 : INF);
      m_active = en;
      m_stim_q = cat | ano | dis;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; en = 1;
    for (int i = 0; i < 2; i++) begin
      req = (i == 0); ch = 4'd9;
      tick();
      total += 5;
      if (start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b want=0", start); end
      if (grant !== 4'd0) begin bad++; $display("FAIL reset_grant got=%0d want=0", grant); end
      if (blank !== 1'b0) begin bad++; $display("FAIL reset_blank got=%b want=0", blank); end
      if (drop !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d want=0", drop); end
      if (flag !== 1'b0) begin bad++; $display("FAIL reset_flag got=%b want=0", flag); end
    end
    rst = 0; req = 1;
    tick();
    total++;
    if (start !== 1'b0) begin bad++; $display("FAIL post_reset_start got=%b want=0", start); end
    req = 0;
    tick();
  endtask

  task automatic test_grant_latency();
    req = 1; ch = 4'd5;
    tick();
    req = 0;
    total += 2;
    if (start !== 1'b1) begin bad++; $display("FAIL latency_start got=%b want=1", start); end
    if (grant !== 4'd5) begin bad++; $display("FAIL latency_grant got=%0d want=5", grant); end
    tick();
    total += 2;
    if (start !== 1'b0) begin bad++; $display("FAIL latency_single got=%b want=0", start); end
    if (grant !== 4'd5) begin bad++; $display("FAIL latency_hold got=%0d want=5", grant); end
  endtask

  task automatic test_back_to_back();
    req = 1; ch = 4'd2;
    tick();
    ch = 4'd11;
    total += 2;
    if (start !== 1'b1 || grant !== 4'd2) begin bad++; $display("FAIL b2b_first got=%b/%0d want=1/2", start, grant); end
    tick();
    req = 0;
    if (start !== 1'b1 || grant !== 4'd11) begin bad++; $display("FAIL b2b_second got=%b/%0d want=1/11", start, grant); end
    tick();
    total++;
    if (start !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b want=0", start); end
  endtask

  task automatic test_blanking();
    int n_blank = 0;
    for (int k = 1; k <= 160; k++) begin
      cat = k <= 150; dis = k > 150;
      req = (k == 40 || k == 100); ch = k[3:0];
      tick();
      if (blank) n_blank++;
      total += 2;
      if (start !== m_start) begin bad++; $display("FAIL blank_start k=%0d got=%b want=%b", k, start, m_start); end
      if (k == 1 && blank !== 1'b0) begin bad++; $display("FAIL blank_early got=%b want=0", blank); end
      if (k == 2 && blank !== 1'b1) begin bad++; $display("FAIL blank_rise got=%b want=1", blank); end
    end
    cat = 0; dis = 0;
    for (int k = 1; k <= 260; k++) begin
      req = (k == 150); ch = 4'd1;
      tick();
      if (blank) n_blank++;
      total += 2;
      if (start !== m_start) begin bad++; $display("FAIL hold_start k=%0d got=%b want=%b", k, start, m_start); end
      if (blank !== exp_blank()) begin bad++; $display("FAIL hold_blank k=%0d got=%b want=%b", k, blank, exp_blank()); end
    end
    req = 0;
    total += 2;
    if (n_blank != 150 + 10 + B) begin bad++; $display("FAIL blank_len got=%0d want=%0d", n_blank, 160 + B); end
    if (drop !== 8'd3) begin bad++; $display("FAIL blank_drops got=%0d want=3", drop); end
  endtask

  task automatic test_restim();
    int run = 0;
    cat = 1;
    repeat (20) tick();
    cat = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      total++;
      if (blank !== 1'b1) begin bad++; $display("FAIL restim_hold k=%0d got=%b want=1", k, blank); end
    end
    cat = 1;
    repeat (5) tick();
    cat = 0;
    for (int k = 0; k < 260; k++) begin
      tick();
      if (blank) run++;
    end
    total++;
    if (run != B + 1) begin bad++; $display("FAIL restim_len got=%0d want=%0d", run, B + 1); end
  endtask

  task automatic test_saturation();
    cat = 1; req = 1;
    for (int k = 0; k < 300; k++) begin ch = k[3:0]; tick(); end
    cat = 0; req = 0;
    tick();
    total++;
    if (drop !== 8'd255) begin bad++; $display("FAIL sat_drop got=%0d want=255", drop); end
    repeat (210) tick();
    total++;
    if (drop !== 8'd255) begin bad++; $display("FAIL sat_hold got=%0d want=255", drop); end
  endtask

  task automatic test_replay();
    int starts = 0;
    rst = 1; tick(); rst = 0; en = 1; tick(); tick();
    cat = 1;
    for (int k = 0; k < 6; k++) begin
      req = (k == 3 || k == 4); ch = (k == 3) ? 4'd3 : 4'd7;
      tick();
    end
    req = 0; cat = 0;
    for (int k = 0; k < 230; k++) begin
      tick();
      if (start) begin
        starts++;
        total += 2;
        if (grant !== `ifdef SAMPLE_REPLAY_EN 4'd3 `else 4'd0 `endif) begin bad++; $display("FAIL replay_grant got=%0d", grant); end
        if (flag !== 1'b1) begin bad++; $display("FAIL replay_flag got=%b want=1", flag); end
      end
    end
    total += 2;
    if (starts != `ifdef SAMPLE_REPLAY_EN 1 `else 0 `endif) begin bad++; $display("FAIL replay_count got=%0d", starts); end
    if (drop !== 8'd2) begin bad++; $display("FAIL replay_drops got=%0d want=2", drop); end
    cat = 1; req = 1; ch = 4'd6;
    tick();
    req = 0;
    repeat (4) tick();
    cat = 0;
    repeat (20) tick();
    en = 0; tick(); en = 1;
    starts = 0;
    repeat (230) begin tick(); if (start) starts++; end
    total++;
    if (starts != 0) begin bad++; $display("FAIL replay_after_disable got=%0d want=0", starts); end
  endtask

  task automatic test_random();
    int stim_left = 0, en_off = 0;
    logic [1:0] ph = '0;
    rst = 1; tick(); rst = 0;
    for (int c = 0; c < 5000; c++) begin
      rst = $urandom_range(0, 999) == 0;
      if (en_off > 0) en_off--;
      else if ($urandom_range(0, 299) == 0) en_off = $urandom_range(1, 8);
      en = en_off == 0;
      if (stim_left > 0) stim_left--;
      else if ($urandom_range(0, 249) == 0) begin stim_left = $urandom_range(1, 60); ph = 2'($urandom_range(0, 2)); end
      cat = stim_left > 0 && ph == 0;
      ano = stim_left > 0 && ph == 1;
      dis = stim_left > 0 && ph == 2;
      req = $urandom_range(0, 2) == 0;
      ch = 4'($urandom);
      tick();
      total += 5;
      if (start !== m_start) begin bad++; $display("FAIL rnd_start c=%0d got=%b want=%b", c, start, m_start); end
      if (grant !== m_grant) begin bad++; $display("FAIL rnd_grant c=%0d got=%0d want=%0d", c, grant, m_grant); end
      if (blank !== exp_blank()) begin bad++; $display("FAIL rnd_blank c=%0d got=%b want=%b", c, blank, exp_blank()); end
      if (drop !== 8'(exp_drop())) begin bad++; $display("FAIL rnd_drop c=%0d got=%0d want=%0d", c, drop, exp_drop()); end
      if (flag !== m_flag) begin bad++; $display("FAIL rnd_flag c=%0d got=%b want=%b", c, flag, m_flag); end
    end
    rst = 0; en = 1; cat = 0; ano = 0; dis = 0; req = 0;
  endtask

  initial begin
    test_reset();
    test_grant_latency();
    test_back_to_back();
    test_blanking();
    test_restim();
    test_saturation();
    test_replay();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
